// File: rtl/rr_grant_capture_pkg.sv
// Shared helpers for the round-robin grant capture stage: one-hot check and
// packed channel-bus slicing, written against generous maximum widths.
package rr_grant_capture_pkg;

    localparam int MAX_CH     = 64;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_BUS    = 4096;

    function automatic logic is_onehot(input logic [MAX_CH-1:0] vec);
        return $countones(vec) == 1;
    endfunction

    // Callers zero-extend their bus to MAX_BUS and truncate the result to their own width.
    function automatic logic [MAX_DATA_W-1:0] bus_slice(input logic [MAX_BUS-1:0] bus,
                                                        input int idx,
                                                        input int width);
        logic [MAX_DATA_W-1:0] mask;
        mask = (MAX_DATA_W'(1) << width) - MAX_DATA_W'(1);
        return MAX_DATA_W'(bus >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/rr_capture_fifo.sv
// Small synchronous FIFO with a register-array head and push-on-pop-when-full.
module rr_capture_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter int FILL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic [FILL_W-1:0] fill
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (fill != '0);
    assign do_push = push && ((fill < FILL_W'(DEPTH)) || do_pop);

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                fill <= fill + 1'b1;
            end else if (!do_push && do_pop) begin
                fill <= fill - 1'b1;
            end
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/rr_grant_capture.sv
// Consumer for a one-hot round-robin grant: captures the granted channel's word
// into a small FIFO, acks the channel, and flags inconsistent grants.
module rr_grant_capture
    import rr_grant_capture_pkg::*;
#(
    parameter int CH     = 32,
    parameter int CH_W   = $clog2(CH),
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2,
    parameter int FILL_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 grant_valid,
    input  logic [CH-1:0]        grant_filt,
    input  logic [CH_W-1:0]      grant_bin,
    input  logic [CH*DATA_W-1:0] ch_data,
    output logic [CH-1:0]        ch_ack,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic [CH_W-1:0]      out_ch,
    input  logic                 out_ready,
    output logic [FILL_W-1:0]    fill,
    output logic                 err_grant
);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t wr_entry;
    entry_t head;
    logic   pop;
    logic   room;
    logic   push;
    logic   filt_bad;

    assign out_valid = (fill != '0);
    assign pop       = out_valid & out_ready;
    assign room      = (fill < FILL_W'(DEPTH)) | pop;
    assign push      = nrst & grant_valid & room;
    assign ch_ack    = push ? grant_filt : '0;

    // Data selection trusts grant_bin even when it disagrees with grant_filt.
    assign wr_entry.ch   = grant_bin;
    assign wr_entry.data = DATA_W'(bus_slice(MAX_BUS'(ch_data), int'(grant_bin), DATA_W));

    assign filt_bad = !is_onehot(MAX_CH'(grant_filt)) ||
                      (grant_filt != (CH'(1) << grant_bin));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            err_grant <= 1'b0;
        end else if (grant_valid && filt_bad) begin
            err_grant <= 1'b1;
        end
    end

    rr_capture_fifo #(
        .WIDTH  (CH_W + DATA_W),
        .DEPTH  (DEPTH),
        .FILL_W (FILL_W)
    ) u_fifo (
        .clk  (clk),
        .nrst (nrst),
        .push (push),
        .pop  (pop),
        .din  (wr_entry),
        .dout (head),
        .fill (fill)
    );

    assign out_data = head.data;
    assign out_ch   = head.ch;

endmodule

// File: tb/tb_rr_grant_capture.sv
// Directed bench for rr_grant_capture with CH=4, DATA_W=8, DEPTH=2.
module tb_rr_grant_capture;

    localparam int CH     = 4;
    localparam int CH_W   = 2;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;
    localparam int FILL_W = 2;

    logic                 clk = 1'b0;
    logic                 nrst;
    logic                 grant_valid;
    logic [CH-1:0]        grant_filt;
    logic [CH_W-1:0]      grant_bin;
    logic [CH*DATA_W-1:0] ch_data;
    logic [CH-1:0]        ch_ack;
    logic                 out_valid;
    logic [DATA_W-1:0]    out_data;
    logic [CH_W-1:0]      out_ch;
    logic                 out_ready;
    logic [FILL_W-1:0]    fill;
    logic                 err_grant;

    int n_cmp = 0;
    int n_err = 0;

    rr_grant_capture #(
        .CH(CH), .CH_W(CH_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FILL_W(FILL_W)
    ) dut (
        .clk(clk), .nrst(nrst), .grant_valid(grant_valid), .grant_filt(grant_filt),
        .grant_bin(grant_bin), .ch_data(ch_data), .ch_ack(ch_ack), .out_valid(out_valid),
        .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready), .fill(fill),
        .err_grant(err_grant)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_grant(input logic [CH-1:0] filt, input logic [CH_W-1:0] bin);
        grant_valid = 1'b1;
        grant_filt  = filt;
        grant_bin   = bin;
    endtask

    task automatic test_reset();
        nrst      = 1'b0;
        out_ready = 1'b0;
        drive_grant(4'b0001, 2'd0);
        @(negedge clk);
        n_cmp++;
        if (ch_ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b want 0000", ch_ack); end
        step();
        grant_valid = 1'b0;
        grant_filt  = '0;
        step();
        nrst = 1'b1;
        n_cmp++;
        if (fill !== 2'd0) begin n_err++; $display("FAIL reset_fill: got %0d want 0", fill); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (err_grant !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_grant); end
        n_cmp++;
        if (out_data !== 8'h00 || out_ch !== 2'd0) begin
            n_err++; $display("FAIL reset_head: got %h/%0d want 00/0", out_data, out_ch);
        end
    endtask

    task automatic test_single_capture();
        out_ready = 1'b1;
        drive_grant(4'b0100, 2'd2);
        @(negedge clk);
        n_cmp++;
        if (ch_ack !== 4'b0100) begin n_err++; $display("FAIL single_ack: got %b want 0100", ch_ack); end
        step();
        grant_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
            n_err++; $display("FAIL single_head: got v=%b %h/%0d want v=1 a5/2", out_valid, out_data, out_ch);
        end
        n_cmp++;
        if (fill !== 2'd1) begin n_err++; $display("FAIL single_fill: got %0d want 1", fill); end
        step();
        n_cmp++;
        if (fill !== 2'd0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL single_drain: got fill=%0d v=%b want 0/0", fill, out_valid);
        end
    endtask

    task automatic test_rotating_full();
        logic [CH-1:0] ack_exp [4];
        ack_exp = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_grant(4'b0001 << i, 2'(i));
            @(negedge clk);
            n_cmp++;
            if (ch_ack !== ack_exp[i]) begin
                n_err++; $display("FAIL rotate_ack[%0d]: got %b want %b", i, ch_ack, ack_exp[i]);
            end
            step();
        end
        grant_valid = 1'b0;
        n_cmp++;
        if (fill !== 2'd2) begin n_err++; $display("FAIL rotate_fill: got %0d want 2", fill); end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hC0 || out_ch !== 2'd0) begin
            n_err++; $display("FAIL rotate_head: got v=%b %h/%0d want v=1 c0/0", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_push_pop_full();
        out_ready = 1'b1;
        drive_grant(4'b1000, 2'd3);
        @(negedge clk);
        n_cmp++;
        if (ch_ack !== 4'b1000) begin n_err++; $display("FAIL fullpp_ack: got %b want 1000", ch_ack); end
        step();
        grant_valid = 1'b0;
        n_cmp++;
        if (fill !== 2'd2 || out_data !== 8'hC1 || out_ch !== 2'd1) begin
            n_err++; $display("FAIL fullpp_pop1: got fill=%0d %h/%0d want 2 c1/1", fill, out_data, out_ch);
        end
        step();
        n_cmp++;
        if (fill !== 2'd1 || out_data !== 8'hC3 || out_ch !== 2'd3) begin
            n_err++; $display("FAIL fullpp_wrap: got fill=%0d %h/%0d want 1 c3/3", fill, out_data, out_ch);
        end
        step();
        n_cmp++;
        if (fill !== 2'd0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL fullpp_drain: got fill=%0d v=%b want 0/0", fill, out_valid);
        end
    endtask

    task automatic test_err_multi_hot();
        out_ready = 1'b1;
        drive_grant(4'b0110, 2'd1);
        @(negedge clk);
        n_cmp++;
        if (ch_ack !== 4'b0110) begin n_err++; $display("FAIL errmh_ack: got %b want 0110", ch_ack); end
        step();
        grant_valid = 1'b0;
        grant_filt  = '0;
        n_cmp++;
        if (err_grant !== 1'b1) begin n_err++; $display("FAIL errmh_set: got %b want 1", err_grant); end
        n_cmp++;
        if (out_data !== 8'hC1 || out_ch !== 2'd1) begin
            n_err++; $display("FAIL errmh_data: got %h/%0d want c1/1", out_data, out_ch);
        end
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (err_grant !== 1'b1) begin n_err++; $display("FAIL errmh_sticky: got %b want 1", err_grant); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        drive_grant(4'b0001, 2'd0);
        step();
        drive_grant(4'b0010, 2'd1);
        step();
        grant_valid = 1'b0;
        n_cmp++;
        if (fill !== 2'd2) begin n_err++; $display("FAIL midrst_prefill: got %0d want 2", fill); end
        nrst      = 1'b0;
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (fill !== 2'd0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_fill: got fill=%0d v=%b want 0/0", fill, out_valid);
        end
        n_cmp++;
        if (out_data !== 8'h00 || out_ch !== 2'd0) begin
            n_err++; $display("FAIL midrst_head: got %h/%0d want 00/0", out_data, out_ch);
        end
        n_cmp++;
        if (err_grant !== 1'b0) begin n_err++; $display("FAIL midrst_err: got %b want 0", err_grant); end
        nrst = 1'b1;
        step();
    endtask

    task automatic test_err_bin_mismatch();
        out_ready   = 1'b0;
        grant_valid = 1'b0;
        grant_filt  = 4'b0110;
        grant_bin   = 2'd0;
        step();
        n_cmp++;
        if (err_grant !== 1'b0 || fill !== 2'd0) begin
            n_err++; $display("FAIL idle_filt: got err=%b fill=%0d want 0/0", err_grant, fill);
        end
        drive_grant(4'b0001, 2'd2);
        @(negedge clk);
        n_cmp++;
        if (ch_ack !== 4'b0001) begin n_err++; $display("FAIL errbin_ack: got %b want 0001", ch_ack); end
        step();
        grant_valid = 1'b0;
        n_cmp++;
        if (err_grant !== 1'b1) begin n_err++; $display("FAIL errbin_set: got %b want 1", err_grant); end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
            n_err++; $display("FAIL errbin_data: got v=%b %h/%0d want v=1 a5/2", out_valid, out_data, out_ch);
        end
    endtask

    initial begin
        nrst        = 1'b0;
        grant_valid = 1'b0;
        grant_filt  = '0;
        grant_bin   = '0;
        out_ready   = 1'b0;
        ch_data     = {8'hC3, 8'hA5, 8'hC1, 8'hC0};
        #1;
        test_reset();
        test_single_capture();
        test_rotating_full();
        test_push_pop_full();
        test_err_multi_hot();
        test_mid_reset();
        test_err_bin_mismatch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
